// File: rtl/switch_conditioner.sv
// Button front end: sync, debounce, edge pulses, and held-combo
// detection for start (0111) and reset request (1111).
module switch_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned COMBO_CYCLES    = 12500000
) (
  input  logic       i_Clk,
  input  logic       i_Reset_n,
  input  logic [3:0] i_Switch,
  output logic [3:0] o_Switch_Level,
  output logic [3:0] o_Switch_Press,
  output logic [3:0] o_Switch_Release,
  output logic       o_Start,
  output logic       o_Reset_Req
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned CW = $clog2(COMBO_CYCLES);
  localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_MAX = CW'(COMBO_CYCLES - 1);
  localparam logic [3:0] PAT_START = 4'b0111;
  localparam logic [3:0] PAT_RESET = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    ARMING,
    FIRED
  } state_t;

  logic [3:0]         sync1_q;
  logic [3:0]         sync2_q;
  logic [3:0][DW-1:0] cnt_q;
  logic [3:0][DW-1:0] cnt_d;
  logic [3:0]         level_q;
  logic [3:0]         level_d;
  logic [3:0]         press_q;
  logic [3:0]         press_d;
  logic [3:0]         release_q;
  logic [3:0]         release_d;

  state_t             state_q;
  logic [3:0]         pat_q;
  logic [CW-1:0]      hold_q;
  logic               start_q;
  logic               rreq_q;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DB_MAX) begin
        level_d[i] = ~level_q[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    press_d   = level_d & ~level_q;
    release_d = ~level_d & level_q;
  end

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      cnt_q     <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      sync1_q   <= i_Switch;
      sync2_q   <= sync1_q;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Combo FSM tracks the level as it is being registered, so it
  // moves in lockstep with o_Switch_Level.
  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q <= IDLE;
      pat_q   <= '0;
      hold_q  <= '0;
      start_q <= 1'b0;
      rreq_q  <= 1'b0;
    end else begin
      start_q <= 1'b0;
      rreq_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (level_d == PAT_START || level_d == PAT_RESET) begin
            pat_q   <= level_d;
            hold_q  <= '0;
            state_q <= ARMING;
          end
        end
        ARMING: begin
          if (level_d != pat_q) begin
            state_q <= IDLE;
          end else if (hold_q == HOLD_MAX) begin
            start_q <= (pat_q == PAT_START);
            rreq_q  <= (pat_q == PAT_RESET);
            state_q <= FIRED;
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        FIRED: begin
          if (level_d != pat_q) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_Switch_Level   = level_q;
  assign o_Switch_Press   = press_q;
  assign o_Switch_Release = release_q;
  assign o_Start          = start_q;
  assign o_Reset_Req      = rreq_q;

endmodule

// File: tb/tb_switch_conditioner.sv
// Bench for switch_conditioner: directed scenarios plus random
// button activity, checked every cycle against a window/timestamp model.
module tb_switch_conditioner;

  localparam int D = 4;
  localparam int C = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] sw;
  logic [3:0] lvl;
  logic [3:0] prs;
  logic [3:0] rel;
  logic       st;
  logic       rr;

  switch_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .COMBO_CYCLES   (C)
  ) dut (
    .i_Clk           (clk),
    .i_Reset_n       (rst_n),
    .i_Switch        (sw),
    .o_Switch_Level  (lvl),
    .o_Switch_Press  (prs),
    .o_Switch_Release(rel),
    .o_Start         (st),
    .o_Reset_Req     (rr)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int nstart = 0;
  int nrr = 0;
  int ncyc = 0;

  // Reference: raw samples per edge, levels, combo timestamps
  logic [3:0] m_hist[$];
  logic [3:0] m_level;
  logic [3:0] m_press;
  logic [3:0] m_rel;
  logic       m_start;
  logic       m_rr;
  int         m_mode;
  logic [3:0] m_pat;
  int         m_arm_at;

  function automatic void model_reset();
    m_hist = {};
    for (int k = 0; k < D + 1; k++) m_hist.push_back(4'b0000);
    m_level = '0;
    m_press = '0;
    m_rel   = '0;
    m_start = 1'b0;
    m_rr    = 1'b0;
    m_mode  = 0;
    m_pat   = '0;
    m_arm_at = 0;
  endfunction

  // A button's level flips once its last D synchronized samples
  // (raw samples from two edges back) all disagree with it.
  function automatic void model_edge(input logic [3:0] raw, input int n);
    logic [3:0] nxt;
    logic       alld;
    m_hist.push_back(raw);
    nxt = m_level;
    for (int b = 0; b < 4; b++) begin
      alld = 1'b1;
      for (int k = 0; k < D; k++)
        if (m_hist[k][b] == m_level[b]) alld = 1'b0;
      if (alld) nxt[b] = ~m_level[b];
    end
    void'(m_hist.pop_front());
    m_press = nxt & ~m_level;
    m_rel   = ~nxt & m_level;
    m_level = nxt;
    m_start = 1'b0;
    m_rr    = 1'b0;
    case (m_mode)
      0: if (nxt == 4'b0111 || nxt == 4'b1111) begin
        m_mode = 1;
        m_pat = nxt;
        m_arm_at = n;
      end
      1: if (nxt != m_pat) begin
        m_mode = 0;
      end else if (n - m_arm_at == C) begin
        m_start = (m_pat == 4'b0111);
        m_rr    = (m_pat == 4'b1111);
        m_mode  = 2;
      end
      default: if (nxt != m_pat) m_mode = 0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] dut_vec();
    return {2'b00, lvl, prs, rel, st, rr};
  endfunction

  function automatic logic [15:0] mdl_vec();
    return {2'b00, m_level, m_press, m_rel, m_start, m_rr};
  endfunction

  task automatic cyc(input int k);
    repeat (k) begin
      @(posedge clk);
      ncyc++;
      if (rst_n) model_edge(sw, ncyc);
      #1;
      chk("cycle", dut_vec(), mdl_vec());
      if (st) nstart++;
      if (rr) nrr++;
    end
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst", dut_vec(), 16'h0000);
  endtask

  initial begin
    rst_n = 1'b0;
    sw = 4'b0000;
    model_reset();
    cyc(3);
    chk("reset_state", dut_vec(), 16'h0000);
    rst_n = 1'b1;
    cyc(3);

    // single press: level/press exactly on the 6th edge
    sw = 4'b0001;
    cyc(5);
    chk("p0_lvl_early", {12'h0, lvl}, 16'h0000);
    cyc(1);
    chk("p0_lvl", {12'h0, lvl}, 16'h0001);
    chk("p0_press", {12'h0, prs}, 16'h0001);
    cyc(1);
    chk("p0_press_once", {12'h0, prs}, 16'h0000);
    sw = 4'b0000;
    cyc(8);

    // 3-cycle glitch is filtered
    sw = 4'b0100;
    cyc(3);
    sw = 4'b0000;
    cyc(10);
    chk("glitch_lvl", {12'h0, lvl}, 16'h0000);

    // start combo held 40 cycles
    nstart = 0;
    nrr = 0;
    sw = 4'b0111;
    cyc(6);
    chk("start_lvl", {12'h0, lvl}, 16'h0007);
    cyc(7);
    chk("start_early", {15'h0, st}, 16'h0000);
    cyc(1);
    chk("start_pulse", {15'h0, st}, 16'h0001);
    cyc(26);
    chk("start_count", 16'(nstart), 16'd1);
    chk("start_no_rr", 16'(nrr), 16'd0);
    sw = 4'b0000;
    cyc(10);

    // 0111 aborted at hold 5 by 1111; re-arm costs one cycle
    nstart = 0;
    nrr = 0;
    sw = 4'b0111;
    cyc(6);
    sw = 4'b1111;
    cyc(6);
    chk("abort_lvl", {12'h0, lvl}, 16'h000f);
    cyc(8);
    chk("abort_rr_early", {15'h0, rr}, 16'h0000);
    cyc(1);
    chk("abort_rr_pulse", {15'h0, rr}, 16'h0001);
    cyc(10);
    chk("abort_no_start", 16'(nstart), 16'd0);
    chk("abort_rr_count", 16'(nrr), 16'd1);
    sw = 4'b0000;
    cyc(10);

    // reset mid-ARMING with all buttons held
    sw = 4'b1111;
    cyc(9);
    async_reset();
    cyc(2);
    rst_n = 1'b1;
    cyc(5);
    chk("rst_press_early", {12'h0, prs}, 16'h0000);
    cyc(1);
    chk("rst_press", {12'h0, prs}, 16'h000f);
    cyc(7);
    chk("rst_rr_early", {15'h0, rr}, 16'h0000);
    cyc(1);
    chk("rst_rr_pulse", {15'h0, rr}, 16'h0001);
    sw = 4'b0000;
    cyc(10);

    // simultaneous press and release on two channels
    sw = 4'b1010;
    cyc(6);
    chk("dual_press", {12'h0, prs}, 16'h000a);
    cyc(4);
    sw = 4'b0000;
    cyc(6);
    chk("dual_release", {12'h0, rel}, 16'h000a);
    cyc(4);

    // random activity, biased toward combos, with stray resets
    for (int it = 0; it < 150; it++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 2) sw = 4'b0111;
      else if (r < 4) sw = 4'b1111;
      else sw = 4'($urandom);
      if ($urandom_range(0, 29) == 0) begin
        async_reset();
        cyc(1);
        rst_n = 1'b1;
      end
      cyc(int'($urandom_range(1, 14)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
